// File: rtl/mc_control_unit.sv
// Multicycle Moore control unit: sequences fetch/decode/memory/execute/writeback,
// owns the NZCV flag register and condition check, and adds a multi-cycle float add.
module mc_control_unit #(
   parameter int unsigned ALUCTRL_W  = 3,
   parameter bit          FLOAT_EN   = 1'b1,
   parameter int unsigned FP_LATENCY = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           Cond,
   input  logic [1:0]           Op,
   input  logic [5:0]           Funct,
   input  logic [3:0]           Rd,
   input  logic [3:0]           ALUFlags,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic [1:0]           ResultSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           RegSrc,
   output logic                 RegWrite,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic [3:0]           Flags,
   output logic                 FPBusy,
   output logic                 Undef,
   output logic [3:0]           State
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned OP_W  = 3;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_FPEXEC = 4'd10
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_fp_cnt;
   logic [3:0]       r_flags;

   logic [3:0]       w_f41;
   logic             w_is_cmp;
   logic             w_is_float;
   logic             w_alu_known;
   logic [OP_W-1:0]  w_alu_op;
   logic             w_undef_instr;
   logic             w_cond_ex;
   logic [1:0]       w_flag_w;
   logic             w_exec_last;
   logic             w_fp_done;

   logic             w_pc_write;
   logic             w_mem_write;
   logic             w_ir_write;
   logic             w_reg_write;
   logic             w_undef;
   logic [OP_W-1:0]  w_alu_sel;

   // Data-processing decode from Funct
   assign w_f41      = Funct[4:1];
   assign w_is_cmp   = (w_f41 == 4'b1010);
   assign w_is_float = FLOAT_EN && (w_f41 == 4'b1100) && !Funct[5];

   always_comb begin
      w_alu_known = 1'b1;
      w_alu_op    = OP_W'(0);
      case (w_f41)
         4'b0100: w_alu_op = OP_W'(0);
         4'b0101: w_alu_op = OP_W'(1);
         4'b0010: w_alu_op = OP_W'(2);
         4'b1010: w_alu_op = OP_W'(2);
         4'b0000: w_alu_op = OP_W'(3);
         default: w_alu_known = 1'b0;
      endcase
   end

   assign w_undef_instr = (Op == 2'b11) || ((Op == 2'b00) && !(w_alu_known || w_is_float));

   // ARM condition table against the stored NZCV
   always_comb begin
      w_cond_ex = 1'b1;
      case (Cond)
         4'b0000: w_cond_ex = r_flags[2];
         4'b0001: w_cond_ex = !r_flags[2];
         4'b0010: w_cond_ex = r_flags[1];
         4'b0011: w_cond_ex = !r_flags[1];
         4'b0100: w_cond_ex = r_flags[3];
         4'b0101: w_cond_ex = !r_flags[3];
         4'b0110: w_cond_ex = r_flags[0];
         4'b0111: w_cond_ex = !r_flags[0];
         4'b1000: w_cond_ex = r_flags[1] && !r_flags[2];
         4'b1001: w_cond_ex = !r_flags[1] || r_flags[2];
         4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
         4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
         4'b1100: w_cond_ex = !r_flags[2] && (r_flags[3] == r_flags[0]);
         4'b1101: w_cond_ex = r_flags[2] || (r_flags[3] != r_flags[0]);
         default: w_cond_ex = 1'b1;
      endcase
   end

   assign w_flag_w    = w_is_cmp ? 2'b11
                      : {Funct[0], Funct[0] && ((w_f41 == 4'b0100) || (w_f41 == 4'b0010))};
   assign w_fp_done   = (r_fp_cnt == '0);
   assign w_exec_last = (r_state == S_EXECR) || (r_state == S_EXECI)
                     || ((r_state == S_FPEXEC) && w_fp_done);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Float latency counter: loaded on entry, exit when it reaches zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fp_cnt <= '0;
      end else if ((r_state == S_DECODE) && (w_next == S_FPEXEC)) begin
         r_fp_cnt <= CNT_W'(FP_LATENCY - 1);
      end else if ((r_state == S_FPEXEC) && !w_fp_done) begin
         r_fp_cnt <= r_fp_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= 4'b0000;
      end else if (w_exec_last && w_cond_ex) begin
         if (w_flag_w[1]) r_flags[3:2] <= ALUFlags[3:2];
         if (w_flag_w[0]) r_flags[1:0] <= ALUFlags[1:0];
      end
   end

   always_comb begin
      w_next      = S_FETCH;
      w_pc_write  = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
      w_undef     = 1'b0;
      AdrSrc      = 1'b0;
      ResultSrc   = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      w_alu_sel   = OP_W'(0);
      FPBusy      = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_next     = S_DECODE;
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ResultSrc = 2'b10;
            if (w_undef_instr) begin
               w_next  = S_FETCH;
               w_undef = 1'b1;
            end else if (Op == 2'b01) begin
               w_next = S_MEMADR;
            end else if (Op == 2'b10) begin
               w_next = S_BRANCH;
            end else if (Funct[5]) begin
               w_next = S_EXECI;
            end else if (w_is_float) begin
               w_next = S_FPEXEC;
            end else begin
               w_next = S_EXECR;
            end
         end
         S_MEMADR: begin
            w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
            ALUSrcB = 2'b01;
         end
         S_MEMRD: begin
            w_next = S_MEMWB;
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc   = 2'b01;
            w_reg_write = w_cond_ex;
            w_pc_write  = w_cond_ex && (Rd == 4'hF);
         end
         S_MEMWR: begin
            AdrSrc      = 1'b1;
            w_mem_write = w_cond_ex;
         end
         S_EXECR, S_EXECI: begin
            w_next    = w_is_cmp ? S_FETCH : S_ALUWB;
            ALUSrcB   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
            w_alu_sel = w_alu_op;
         end
         S_FPEXEC: begin
            w_next    = w_fp_done ? S_ALUWB : S_FPEXEC;
            w_alu_sel = OP_W'(4);
            FPBusy    = 1'b1;
         end
         S_ALUWB: begin
            w_reg_write = w_cond_ex;
            w_pc_write  = w_cond_ex && (Rd == 4'hF);
         end
         S_BRANCH: begin
            ALUSrcB    = 2'b01;
            ResultSrc  = 2'b10;
            w_pc_write = w_cond_ex;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Immediate format and register-read select follow the instruction class
   always_comb begin
      ImmSrc = 2'b00;
      RegSrc = 2'b00;
      case (Op)
         2'b01: begin ImmSrc = 2'b01; RegSrc = 2'b10; end
         2'b10: begin ImmSrc = 2'b10; RegSrc = 2'b01; end
         default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
      endcase
   end

   assign PCWrite    = w_pc_write  && reset;
   assign MemWrite   = w_mem_write && reset;
   assign IRWrite    = w_ir_write  && reset;
   assign RegWrite   = w_reg_write && reset;
   assign Undef      = w_undef     && reset;
   assign ALUControl = ALUCTRL_W'(w_alu_sel);
   assign Flags      = r_flags;
   assign State      = r_state;

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multicycle successor to the single-cycle main/ALU decoder. It turns the decoded instruction fields into a Moore FSM that sequences fetch, decode, memory, execute and writeback, one datapath step per clock. It owns the NZCV flag register and condition evaluation, and adds a parametrised multi-cycle floating-point add mode. It sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
ALUCTRL_W, 3, width of ALUControl; must be >= 3, upper bits zero-filled.
FLOAT_EN, 1, 1 = Funct[4:1]=1100 runs as a float add; 0 = that encoding is undefined.
FP_LATENCY, 3, cycles spent in FPEXEC; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
Cond  in  4  Instr[31:28].
Op  in  2  Instr[27:26].
Funct  in  6  Instr[25:20].
Rd  in  4  Instr[15:12].
ALUFlags  in  4  N,Z,C,V from the ALU, bit 3 = N.
PCWrite  out  1  PC load enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
MemWrite  out  1  data memory write enable.
IRWrite  out  1  instruction register load enable.
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result.
ALUSrcA  out  1  0 = register A, 1 = PC.
ALUSrcB  out  2  00 = register B, 01 = ExtImm, 10 = constant 4.
ImmSrc  out  2  immediate format select.
RegSrc  out  2  register-read address select.
RegWrite  out  1  register file write enable.
ALUControl  out  ALUCTRL_W  ALU operation.
Flags  out  4  stored NZCV.
FPBusy  out  1  high in every FPEXEC cycle.
Undef  out  1  one-cycle pulse in DECODE when the instruction is undefined.
State  out  4  current state, for debug.

Behaviour:
- Reset (reset = 0): State = FETCH (0), Flags = 0000, FP counter = 0. PCWrite, IRWrite, RegWrite, MemWrite and Undef are forced to 0. Other outputs take their FETCH values. Reset asserted in any state, including mid-FPEXEC, aborts to FETCH immediately.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, FPEXEC 10. Any other encoding goes to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, Op=01 -> MEMADR.
  - DECODE, Op=10 -> BRANCH.
  - DECODE, Op=00 with Funct[5]=1 -> EXECI.
  - DECODE, Op=00, Funct[5]=0, float encoding and FLOAT_EN -> FPEXEC.
  - DECODE, Op=00 otherwise -> EXECR.
  - DECODE, Op=11 or unsupported Funct[4:1] -> FETCH, with Undef=1 for that cycle.
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB -> FETCH. MEMWR -> FETCH. BRANCH -> FETCH.
  - EXECR/EXECI -> FETCH when Funct[4:1]=1010 (CMP), else ALUWB. ALUWB -> FETCH.
  - FPEXEC: counter loads FP_LATENCY-1 on entry and decrements each cycle; exit to ALUWB when it is 0. FP_LATENCY=1 gives exactly one FPEXEC cycle.
- Outputs per state (unlisted enables = 0):
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU=ADD.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - EXECR: ALUSrcB=00, decoded op.
  - EXECI: ALUSrcB=01, decoded op.
  - FPEXEC: ALUSrcB=00, float op, FPBusy=1.
  - ALUWB: ResultSrc=00, RegWrite=CondEx.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx.
  - In MEMWB/ALUWB with Rd=1111: PCWrite=CondEx.
- ImmSrc/RegSrc are combinational from Op: 00 -> 00/00; 01 -> 01/10; 10 -> 10/01.
- ALU decode, Funct[4:1] -> ALUControl: 0100 -> 0 (ADD), 0101 -> 1, 0010 -> 2 (SUB), 1010 -> 2 (CMP), 0000 -> 3 (AND), 1100 -> 4 (FADD, only when FLOAT_EN). Non-execute states use ADD.
- Condition evaluation:
  - CondEx is combinational from Cond and the stored Flags, using the standard ARM table; 1110 and 1111 are always-true.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (op is ADD, SUB or CMP).
  - Update happens only at the final execute cycle (EXECR, EXECI, or the last FPEXEC cycle) when CondEx=1. FlagW[1] loads N,Z from ALUFlags; FlagW[0] loads C,V.
  - CMP forces FlagW = 11.
  - Flags never change in any other state.

Test Plan:
- Reset low in FPEXEC with counter=1 -> same cycle State=0, PCWrite=0. Release reset -> next edge State=1.
- ADD register, S=1, Cond=1110, ALUFlags=0100 -> states 0,1,6,8,0. RegWrite=1 only in state 8. Flags=0100 after leaving state 6.
- LDR (Op=01, Funct[0]=1) -> states 0,1,2,3,4,0. AdrSrc=1 in state 3. ResultSrc=01 and RegWrite=1 in state 4.
- Branch with Cond=0000 (EQ) and Flags=0000 -> states 0,1,9,0 with PCWrite=0 in state 9. Repeat with Flags=0100 -> PCWrite=1 in state 9.
- FLOAT_EN=1, FP_LATENCY=3, Funct[4:1]=1100 -> exactly 3 consecutive cycles in state 10 with FPBusy=1 and ALUControl=4, then state 8. With FLOAT_EN=0 -> Undef pulse in state 1, then state 0.
- CMP, Cond=1110, ALUFlags=1001 -> Flags=1001, state 6 goes directly to 0, RegWrite never asserted. Next ADD with Cond=1010 (GE) executes with RegWrite=1.
